note_key_mapper: RTL and testbench
==================================

// Module: note_key_mapper
// PURPOSE
//  Parametrised key-to-note front end for the buzzer player: debounces note, length and octave keys, then does one of two things.
//  - Play mode: maps each note-key press through a rewritable table and emits one note event {note, length, octave} per press.
//  - Write mode (rw=1): presses reprogram the note/length tables, one pulsed write per edge.
//  Sits between board switches/buttons and the tone generator / tube display.
// PARAMETERS
//  NUM_KEYS      7          note keys and length keys (same count)
//  NOTE_W        4          note code width
//  LEN_W         3          length code width
//  OCT_W         2          octave width
//  OCT_MAX       3          octave upper bound (lower bound fixed at 0)
//  OCT_RESET     1          octave after reset
//  DEBOUNCE_CYC  2000000    clk cycles an input must be stable before it is accepted (20 ms @ 100 MHz)
// PORTS
//  clk         in   1         system clock
//  rst_n       in   1         asynchronous active-low reset
//  rw          in   1         1 = write (remap) mode, 0 = play mode; level, 2-flop synchronised only
//  oct_up      in   1         raw button: octave +1
//  oct_down    in   1         raw button: octave -1
//  note_key    in   NUM_KEYS  raw note switches
//  length_key  in   NUM_KEYS  raw length switches
//  new_note    in   NOTE_W    data written into note table in write mode
//  new_length  in   LEN_W     data written into length table in write mode
//  evt_valid   out  1         note event pending
//  evt_ready   in   1         consumer accepts event when evt_valid & evt_ready
//  evt_note    out  NOTE_W    mapped note
//  evt_length  out  LEN_W     current length code at press time
//  evt_octave  out  OCT_W     octave at press time
//  octave      out  OCT_W     live octave (for display)
//  wr_done     out  1         one-cycle pulse per table write
// BEHAVIOUR
//  - Reset:
//    - note_tab[i] = i and len_tab[i] = i, truncated to width.
//    - cur_len = 0; octave = OCT_RESET.
//    - evt_valid = 0, evt_* = 0, wr_done = 0; all debouncers cleared to 0.
//  - Input conditioning: each raw bit passes a 2-flop sync, then a debouncer.
//    - Debounced level D updates only after DEBOUNCE_CYC consecutive cycles of equal synced value.
//    - Edge = rising edge of D (D=1, D_prev=0), seen in cycle T.
//  - Priority: several rising edges in the same vector and same cycle -> lowest index wins, the rest are dropped.
//  - Play mode, length edge i at T: cur_len <= len_tab[i] at T+1.
//  - Play mode, note edge i at T with evt_valid=0, or evt_valid=1 & evt_ready=1:
//    - At T+1: evt_valid=1, evt_note=note_tab[i], evt_length=cur_len, evt_octave=octave.
//    - Values are as sampled at T; a same-cycle length edge is NOT applied to this event.
//  - evt_valid=1 & evt_ready=0: note edge dropped (single-entry buffer); evt_* hold stable until accepted.
//  - Accept with no new edge: evt_valid=0 next cycle.
//  - Write mode, note edge i at T: note_tab[i] <= new_note at T+1; wr_done=1 at T+1 only.
//  - Write mode, length edge i at T: len_tab[i] <= new_length at T+1; wr_done=1 at T+1 only.
//  - Write mode, note and length edge in the same cycle: both written; single wr_done pulse.
//  - Write mode issues no events; a pending event still drains via evt_ready.
//  - Octave:
//    - oct_up edge: +1, saturating at OCT_MAX.
//    - oct_down edge: -1, saturating at 0.
//    - Both edges in the same cycle: no change.
//    - Active in both modes.
//  - rw toggle mid-operation: takes effect 2 cycles later (sync); keys already held do not re-edge.
//  - Async reset mid-event: evt_valid drops immediately; tables return to identity.
// STRUCTURE
//  - Constants.vh: NOTE_KEY_BITS, LENGTH_KEY_BITS, NOTE_BITS, LENGTH_BITS, OCT bounds, DEBOUNCE default (defaults above derive from these).
//  - Sub-module key_debouncer #(W, DEBOUNCE_CYC): sync + per-bit stability counter + registered D/D_prev, rising-edge vector out.
//    - Three instances: note, length, {oct_up, oct_down}.
//  - Top holds: tables, priority encoder, octave register, event register/handshake.
// TESTING (DEBOUNCE_CYC=4 in sim)
//  - Reset, play, hold note_key[3] 10 cycles -> one event: note=3, length=0, octave=1; evt_valid holds until evt_ready.
//  - rw=1, new_note=9, pulse note_key[2] -> wr_done 1 cycle; rw=0, press key 2 -> evt_note=9.
//  - 3-cycle glitch on note_key[0] -> no event; keys 1 and 4 rise together -> single event, note=1.
//  - oct_up x4 from reset -> octave 2,3,3,3; oct_up+oct_down together -> unchanged.
//  - evt_ready=0, press keys 5 then 6 -> only note=5 delivered, key 6 dropped; evt_* stable throughout.
//  - Press length_key[4] then note_key[0] -> evt_length=4; assert rst_n=0 mid-event -> evt_valid=0, tables identity.

Source files
------------

// File: rtl/note_key_mapper_pkg.sv
// -----------------------------------------------------------------------------
// note_key_mapper_pkg
// Shared configuration for the key-to-note front end: key count, code widths,
// octave bounds, default debounce time, the code types built from them and two
// small helpers (lowest-index key select, saturating octave step).
// No ports; imported by the interface, the debouncer and the top.
// -----------------------------------------------------------------------------
package note_key_mapper_pkg;

    localparam int NUM_KEYS         = 7;        // note keys and length keys
    localparam int NOTE_W           = 4;        // note code width
    localparam int LEN_W            = 3;        // length code width
    localparam int OCT_W            = 2;        // octave width
    localparam int OCT_MAX          = 3;        // octave upper bound (lower is 0)
    localparam int OCT_RESET        = 1;        // octave after reset
    localparam int DEBOUNCE_CYC_DEF = 2000000;  // 20 ms at 100 MHz
    localparam int KEY_IDX_W        = $clog2(NUM_KEYS);

    typedef logic [NUM_KEYS-1:0]  key_vec_t;
    typedef logic [KEY_IDX_W-1:0] key_idx_t;
    typedef logic [NOTE_W-1:0]    note_t;
    typedef logic [LEN_W-1:0]     len_t;
    typedef logic [OCT_W-1:0]     oct_t;

    // Index of the lowest set bit; zero when nothing is set (callers gate
    // the result with a reduction-OR of the same vector).
    function automatic key_idx_t lowest_set(input key_vec_t v);
        key_idx_t idx;
        idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = key_idx_t'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One octave step: up/down saturate at the bounds, both together cancel.
    function automatic oct_t oct_step(input oct_t cur, input logic up, input logic down);
        oct_t nxt;
        nxt = cur;
        if (up && !down) begin
            if (cur < oct_t'(OCT_MAX)) begin
                nxt = cur + oct_t'(1);
            end else begin
                nxt = cur;
            end
        end else if (down && !up) begin
            if (cur > oct_t'(0)) begin
                nxt = cur - oct_t'(1);
            end else begin
                nxt = cur;
            end
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/note_key_mapper_if.sv
// -----------------------------------------------------------------------------
// note_key_mapper_if
// Note-event handshake toward the tone generator / display.
//   evt_valid  : event pending (mapper -> consumer)
//   evt_ready  : consumer accepts when evt_valid & evt_ready
//   evt_note   : mapped note code
//   evt_length : length code current at press time
//   evt_octave : octave at press time
// master = mapper side, slave = consumer side.
// -----------------------------------------------------------------------------
interface note_key_mapper_if
    import note_key_mapper_pkg::*;
    ();

    logic  evt_valid;
    logic  evt_ready;
    note_t evt_note;
    len_t  evt_length;
    oct_t  evt_octave;

    modport master (
        output evt_valid,
        output evt_note,
        output evt_length,
        output evt_octave,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_note,
        input  evt_length,
        input  evt_octave,
        output evt_ready
    );

endinterface

// File: rtl/note_key_mapper_debouncer.sv
// -----------------------------------------------------------------------------
// note_key_mapper_debouncer
// W independent raw inputs, each through a 2-flop synchroniser and a
// stability counter. The debounced level only follows the synchronised value
// after it has differed from the level for DEBOUNCE_CYC consecutive cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (all state to 0)
//   raw_i      : raw switch/button bits
//   rise_o     : one-cycle pulse per rising edge of the debounced level
// -----------------------------------------------------------------------------
module note_key_mapper_debouncer #(
    parameter int W            = 1,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [W-1:0]     sync1_q;
    logic [W-1:0]     sync2_q;
    logic [W-1:0]     lvl_q;
    logic [W-1:0]     lvl_d;
    logic [W-1:0]     lvl_prev_q;
    logic [CNT_W-1:0] cnt_q [W];
    logic [CNT_W-1:0] cnt_d [W];

    // Synchroniser, debounced level, previous level and stability counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw_i;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Count cycles the synced value disagrees with the level; any agreement
    // restarts the count, so a glitch shorter than DEBOUNCE_CYC never lands.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < W; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    lvl_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign rise_o = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/note_key_mapper.sv
// -----------------------------------------------------------------------------
// note_key_mapper
// Key-to-note front end for the buzzer player. Debounces note, length and
// octave keys. Play mode maps a note-key press through a rewritable table and
// emits one {note, length, octave} event; write mode reprograms the tables.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   rw_i          : 1 = write (remap) mode, 0 = play; synchronised only
//   oct_up_i      : raw octave +1 button
//   oct_down_i    : raw octave -1 button
//   note_key_i    : raw note switches
//   length_key_i  : raw length switches
//   new_note_i    : note-table write data
//   new_length_i  : length-table write data
//   evt_if        : note-event handshake (master side)
//   octave_o      : live octave for the display
//   wr_done_o     : one-cycle pulse per table write
// -----------------------------------------------------------------------------
module note_key_mapper
    import note_key_mapper_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rw_i,
    input  logic              oct_up_i,
    input  logic              oct_down_i,
    input  key_vec_t          note_key_i,
    input  key_vec_t          length_key_i,
    input  note_t             new_note_i,
    input  len_t              new_length_i,
    note_key_mapper_if.master evt_if,
    output oct_t              octave_o,
    output logic              wr_done_o
);

    key_vec_t   note_rise_s;
    key_vec_t   len_rise_s;
    logic [1:0] oct_rise_s;     // [1] = up, [0] = down
    logic       note_hit_s;
    logic       len_hit_s;
    key_idx_t   note_idx_s;
    key_idx_t   len_idx_s;
    logic       free_s;

    logic  rw_meta_q;
    logic  rw_q;
    note_t note_tab_q [NUM_KEYS];
    note_t note_tab_d [NUM_KEYS];
    len_t  len_tab_q  [NUM_KEYS];
    len_t  len_tab_d  [NUM_KEYS];
    len_t  cur_len_q,   cur_len_d;
    oct_t  octave_q,    octave_d;
    logic  evt_valid_q, evt_valid_d;
    note_t evt_note_q,  evt_note_d;
    len_t  evt_len_q,   evt_len_d;
    oct_t  evt_oct_q,   evt_oct_d;
    logic  wr_done_q,   wr_done_d;

    note_key_mapper_debouncer #(.W(NUM_KEYS), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_note (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (note_key_i),
        .rise_o (note_rise_s)
    );

    note_key_mapper_debouncer #(.W(NUM_KEYS), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_len (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (length_key_i),
        .rise_o (len_rise_s)
    );

    note_key_mapper_debouncer #(.W(2), .DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_oct (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  ({oct_up_i, oct_down_i}),
        .rise_o (oct_rise_s)
    );

    // Several simultaneous edges: the lowest index is taken, the rest dropped.
    assign note_hit_s = |note_rise_s;
    assign len_hit_s  = |len_rise_s;
    assign note_idx_s = lowest_set(note_rise_s);
    assign len_idx_s  = lowest_set(len_rise_s);

    // Event slot can take a new note when empty or being drained this cycle.
    assign free_s = !evt_valid_q || evt_if.evt_ready;

    // Mode synchroniser, tables, length/octave state and event register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_meta_q   <= 1'b0;
            rw_q        <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                note_tab_q[i] <= note_t'(i);
                len_tab_q[i]  <= len_t'(i);
            end
            cur_len_q   <= '0;
            octave_q    <= oct_t'(OCT_RESET);
            evt_valid_q <= 1'b0;
            evt_note_q  <= '0;
            evt_len_q   <= '0;
            evt_oct_q   <= '0;
            wr_done_q   <= 1'b0;
        end else begin
            rw_meta_q   <= rw_i;
            rw_q        <= rw_meta_q;
            for (int i = 0; i < NUM_KEYS; i++) begin
                note_tab_q[i] <= note_tab_d[i];
                len_tab_q[i]  <= len_tab_d[i];
            end
            cur_len_q   <= cur_len_d;
            octave_q    <= octave_d;
            evt_valid_q <= evt_valid_d;
            evt_note_q  <= evt_note_d;
            evt_len_q   <= evt_len_d;
            evt_oct_q   <= evt_oct_d;
            wr_done_q   <= wr_done_d;
        end
    end

    // Next state: table writes in write mode, length select and note events in
    // play mode. The event takes cur_len_q/octave_q as they stand this cycle,
    // so a length or octave edge in the same cycle only affects later events.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            note_tab_d[i] = note_tab_q[i];
            len_tab_d[i]  = len_tab_q[i];
        end
        cur_len_d   = cur_len_q;
        evt_valid_d = evt_valid_q;
        evt_note_d  = evt_note_q;
        evt_len_d   = evt_len_q;
        evt_oct_d   = evt_oct_q;
        wr_done_d   = 1'b0;
        octave_d    = oct_step(octave_q, oct_rise_s[1], oct_rise_s[0]);

        if (evt_valid_q && evt_if.evt_ready) begin
            evt_valid_d = 1'b0;
        end else begin
            evt_valid_d = evt_valid_q;
        end

        if (rw_q) begin
            if (note_hit_s) begin
                note_tab_d[note_idx_s] = new_note_i;
            end else begin
                note_tab_d[note_idx_s] = note_tab_q[note_idx_s];
            end
            if (len_hit_s) begin
                len_tab_d[len_idx_s] = new_length_i;
            end else begin
                len_tab_d[len_idx_s] = len_tab_q[len_idx_s];
            end
            wr_done_d = note_hit_s || len_hit_s;
        end else begin
            if (len_hit_s) begin
                cur_len_d = len_tab_q[len_idx_s];
            end else begin
                cur_len_d = cur_len_q;
            end
            if (note_hit_s && free_s) begin
                evt_valid_d = 1'b1;
                evt_note_d  = note_tab_q[note_idx_s];
                evt_len_d   = cur_len_q;
                evt_oct_d   = octave_q;
            end else begin
                evt_note_d  = evt_note_q;
            end
        end
    end

    assign evt_if.evt_valid  = evt_valid_q;
    assign evt_if.evt_note   = evt_note_q;
    assign evt_if.evt_length = evt_len_q;
    assign evt_if.evt_octave = evt_oct_q;
    assign octave_o          = octave_q;
    assign wr_done_o         = wr_done_q;

endmodule

// File: tb/tb_note_key_mapper.sv
// -----------------------------------------------------------------------------
// tb_note_key_mapper
// Directed vectors with hand-computed expectations for note_key_mapper,
// debounce shortened to 4 cycles. Inputs driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_note_key_mapper;
    import note_key_mapper_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    logic     rw;
    logic     oct_up;
    logic     oct_down;
    key_vec_t note_key;
    key_vec_t length_key;
    note_t    new_note;
    len_t     new_length;
    oct_t     octave;
    logic     wr_done;

    int n_vec  = 0;
    int n_err  = 0;
    int wr_cnt = 0;

    note_key_mapper_if u_if ();

    note_key_mapper #(.DEBOUNCE_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rw_i         (rw),
        .oct_up_i     (oct_up),
        .oct_down_i   (oct_down),
        .note_key_i   (note_key),
        .length_key_i (length_key),
        .new_note_i   (new_note),
        .new_length_i (new_length),
        .evt_if       (u_if),
        .octave_o     (octave),
        .wr_done_o    (wr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, counting cycles with wr_done high.
    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (wr_done === 1'b1) wr_cnt++;
        end
    endtask

    // Hold a key pattern long enough to debounce, then release and settle.
    task automatic press(input key_vec_t nk, input key_vec_t lk, input logic up, input logic dn);
        note_key   = nk;
        length_key = lk;
        oct_up     = up;
        oct_down   = dn;
        run(10);
        note_key   = '0;
        length_key = '0;
        oct_up     = 1'b0;
        oct_down   = 1'b0;
        run(10);
    endtask

    task automatic accept();
        u_if.evt_ready = 1'b1;
        run(1);
        u_if.evt_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; rw = 1'b0; oct_up = 1'b0; oct_down = 1'b0;
        note_key = '0; length_key = '0; new_note = '0; new_length = '0;
        u_if.evt_ready = 1'b0;
        #1 rst_n = 1'b0;
        run(3);
        chk("rst_valid", u_if.evt_valid, 0);
        chk("rst_note", u_if.evt_note, 0);
        chk("rst_octave", octave, 1);
        chk("rst_wr_done", wr_done, 0);
        rst_n = 1'b1;
        run(2);

        // Hold key 3: debounce latency then one event note=3 len=0 oct=1.
        note_key = 7'b0001000;
        run(6);
        chk("lat_early", u_if.evt_valid, 0);
        run(1);
        chk("lat_valid", u_if.evt_valid, 1);
        run(3);
        note_key = '0;
        run(10);
        chk("k3_valid_held", u_if.evt_valid, 1);
        chk("k3_note", u_if.evt_note, 3);
        chk("k3_len", u_if.evt_length, 0);
        chk("k3_oct", u_if.evt_octave, 1);
        accept();
        chk("k3_drained", u_if.evt_valid, 0);
        run(10);
        chk("k3_single", u_if.evt_valid, 0);

        // Write mode: remap key 2 to note 9, single wr_done, no event.
        rw = 1'b1;
        run(4);
        new_note = 4'd9;
        wr_cnt = 0;
        press(7'b0000100, '0, 1'b0, 1'b0);
        chk("wr_pulses", wr_cnt, 1);
        chk("wr_no_evt", u_if.evt_valid, 0);
        rw = 1'b0;
        run(4);
        press(7'b0000100, '0, 1'b0, 1'b0);
        chk("remap_note", u_if.evt_note, 9);
        accept();

        // Short glitch ignored; two keys together -> lowest index only.
        note_key = 7'b0000001;
        run(3);
        note_key = '0;
        run(12);
        chk("glitch_no_evt", u_if.evt_valid, 0);
        press(7'b0010010, '0, 1'b0, 1'b0);
        chk("prio_valid", u_if.evt_valid, 1);
        chk("prio_note", u_if.evt_note, 1);
        accept();
        run(5);
        chk("prio_single", u_if.evt_valid, 0);

        // Octave saturation and cancelling.
        press('0, '0, 1'b1, 1'b0);
        chk("oct_up1", octave, 2);
        press('0, '0, 1'b1, 1'b0);
        chk("oct_up2", octave, 3);
        press('0, '0, 1'b1, 1'b0);
        chk("oct_up3", octave, 3);
        press('0, '0, 1'b1, 1'b0);
        chk("oct_up4", octave, 3);
        press('0, '0, 1'b1, 1'b1);
        chk("oct_both", octave, 3);
        press('0, '0, 1'b0, 1'b1);
        chk("oct_down", octave, 2);

        // Back-pressure: key 5 held in the slot, key 6 dropped.
        press(7'b0100000, '0, 1'b0, 1'b0);
        chk("bp_note5", u_if.evt_note, 5);
        chk("bp_oct", u_if.evt_octave, 2);
        note_key = 7'b1000000;
        run(10);
        chk("bp_stable_mid", u_if.evt_note, 5);
        note_key = '0;
        run(10);
        chk("bp_stable_end", u_if.evt_note, 5);
        accept();
        chk("bp_drained", u_if.evt_valid, 0);
        run(5);
        chk("bp_k6_dropped", u_if.evt_valid, 0);

        // Write both tables at once on key 6: one wr_done pulse.
        rw = 1'b1;
        run(4);
        new_note = 4'd12;
        new_length = 3'd5;
        wr_cnt = 0;
        press(7'b1000000, 7'b1000000, 1'b0, 1'b0);
        chk("wr_both_pulses", wr_cnt, 1);
        rw = 1'b0;
        run(4);
        press('0, 7'b1000000, 1'b0, 1'b0);
        press(7'b1000000, '0, 1'b0, 1'b0);
        chk("wr_both_note", u_if.evt_note, 12);
        chk("wr_both_len", u_if.evt_length, 5);
        accept();

        // Length key 4 then note key 0.
        press('0, 7'b0010000, 1'b0, 1'b0);
        press(7'b0000001, '0, 1'b0, 1'b0);
        chk("len4_note", u_if.evt_note, 0);
        chk("len4_len", u_if.evt_length, 4);

        // Asynchronous reset while the event is pending.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", u_if.evt_valid, 0);
        chk("arst_octave", octave, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run(2);
        press('0, 7'b1000000, 1'b0, 1'b0);
        press(7'b1000000, '0, 1'b0, 1'b0);
        chk("id_note6", u_if.evt_note, 6);
        chk("id_len6", u_if.evt_length, 6);
        chk("id_oct", u_if.evt_octave, 1);
        accept();
        press(7'b0000100, '0, 1'b0, 1'b0);
        chk("id_note2", u_if.evt_note, 2);
        accept();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
